// File: rtl/pong_ball_engine_if.sv
// Frame-rate bus between the pong engine and its neighbours: paddle inputs,
// frame strobe and serve request in; registered ball, score and state out.
interface pong_ball_engine_if;
    logic       frame_tick;
    logic       serve;
    logic [8:0] p1_y;
    logic [8:0] p2_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       point_pulse;
    logic       game_over;
    logic [1:0] state;

    modport master (
        output frame_tick, serve, p1_y, p2_y,
        input  ball_x, ball_y, score_p1, score_p2, point_pulse, game_over, state
    );

    modport slave (
        input  frame_tick, serve, p1_y, p2_y,
        output ball_x, ball_y, score_p1, score_p2, point_pulse, game_over, state
    );
endinterface

// File: rtl/pong_ball_engine.sv
// Pong game-state engine: ball motion, wall/paddle collision, scoring and the
// IDLE/SERVE/PLAY/GAME_OVER sequence. Define PONG_SPEEDUP_EN for paddle-hit speedup.
module pong_ball_engine #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 4,
    parameter int PADDLE_W     = 5,
    parameter int PADDLE_H     = 50,
    parameter int P1_X         = 0,
    parameter int P2_X         = 635,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic             pixel_clk,
    input  logic             reset,
    pong_ball_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, GAME_OVER = 2'd3} state_t;

    localparam int                 CW    = $clog2(SERVE_FRAMES + 1);
    localparam logic [9:0]         CX    = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]         CY    = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - BALL_SIZE);
    localparam logic signed [11:0] X_L   = 12'(P1_X + PADDLE_W);
    localparam logic signed [11:0] X_R   = 12'(P2_X - BALL_SIZE);
    localparam logic signed [11:0] BS    = 12'(BALL_SIZE);
    localparam logic signed [11:0] PH    = 12'(PADDLE_H);
    localparam logic signed [11:0] P2X   = 12'(P2_X);
    localparam logic signed [11:0] SW    = 12'(SCREEN_W);
    localparam logic [3:0]         WIN   = 4'(WIN_SCORE);

    state_t        state_q;
    logic [9:0]    ball_x_q, ball_y_q;
    logic          vx_neg_q, vy_neg_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    sc1_q, sc2_q;
    logic          pulse_q, over_q;
    logic [2:0]    spd;

    logic signed [11:0] bx, by, vx, vy, nx, ny, p1, p2;
    logic [9:0]         ball_y_d;
    logic               vy_neg_d;
    logic               hit_l, hit_r, miss_l, miss_r;
    logic [3:0]         sc1_d, sc2_d;
    logic               win_d;

    // Candidate next position; every rule below judges it against the current frame.
    always_comb begin
        bx       = 12'(ball_x_q);
        by       = 12'(ball_y_q);
        p1       = 12'(bus.p1_y);
        p2       = 12'(bus.p2_y);
        vx       = vx_neg_q ? -12'(spd) : 12'(spd);
        vy       = vy_neg_q ? -12'sd1 : 12'sd1;
        nx       = bx + vx;
        ny       = by + vy;
        ball_y_d = ny[9:0];
        vy_neg_d = vy_neg_q;
        if (ny <= 0) begin
            ball_y_d = '0;
            vy_neg_d = 1'b0;
        end else if (ny >= Y_MAX) begin
            ball_y_d = Y_MAX[9:0];
            vy_neg_d = 1'b1;
        end
        hit_l  = vx_neg_q && (nx <= X_L) && (by < p1 + PH) && (p1 < by + BS);
        hit_r  = !vx_neg_q && (nx + BS >= P2X) && (by < p2 + PH) && (p2 < by + BS);
        miss_l = nx < 0;
        miss_r = nx + BS > SW;
        sc1_d  = (sc1_q < WIN) ? sc1_q + 4'd1 : sc1_q;
        sc2_d  = (sc2_q < WIN) ? sc2_q + 4'd1 : sc2_q;
        win_d  = miss_l ? (sc2_d == WIN) : (sc1_d == WIN);
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ball_x_q <= CX;
            ball_y_q <= CY;
            vx_neg_q <= 1'b0;
            vy_neg_q <= 1'b0;
            cnt_q    <= '0;
            sc1_q    <= '0;
            sc2_q    <= '0;
            pulse_q  <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (bus.frame_tick) begin
                case (state_q)
                    IDLE: begin
                        if (bus.serve) begin
                            state_q <= SERVE;
                            cnt_q   <= '0;
                        end
                    end
                    SERVE: begin
                        ball_x_q <= CX;
                        ball_y_q <= CY;
                        vy_neg_q <= 1'b0;
                        if (cnt_q == CW'(SERVE_FRAMES - 1)) state_q <= PLAY;
                        else                                 cnt_q   <= cnt_q + CW'(1);
                    end
                    PLAY: begin
                        ball_y_q <= ball_y_d;
                        vy_neg_q <= vy_neg_d;
                        if (hit_l) begin
                            ball_x_q <= X_L[9:0];
                            vx_neg_q <= 1'b0;
                        end else if (hit_r) begin
                            ball_x_q <= X_R[9:0];
                            vx_neg_q <= 1'b1;
                        end else if (miss_l || miss_r) begin
                            // Next serve heads toward whoever just lost the point.
                            pulse_q  <= 1'b1;
                            ball_x_q <= CX;
                            ball_y_q <= CY;
                            vx_neg_q <= miss_l;
                            vy_neg_q <= 1'b0;
                            cnt_q    <= '0;
                            if (miss_l) sc2_q <= sc2_d;
                            else        sc1_q <= sc1_d;
                            state_q  <= win_d ? GAME_OVER : SERVE;
                            over_q   <= win_d;
                        end else begin
                            ball_x_q <= nx[9:0];
                        end
                    end
                    GAME_OVER: begin
                        if (bus.serve) begin
                            sc1_q   <= '0;
                            sc2_q   <= '0;
                            cnt_q   <= '0;
                            over_q  <= 1'b0;
                            state_q <= SERVE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef PONG_SPEEDUP_EN
    logic [2:0] spd_q;
    logic [1:0] hits_q;
    assign spd = spd_q;

    // Every fourth paddle return adds one pixel/frame, up to four; a point resets it.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            spd_q  <= 3'd1;
            hits_q <= '0;
        end else if (bus.frame_tick && state_q == PLAY) begin
            if (hit_l || hit_r) begin
                hits_q <= hits_q + 2'd1;
                if (hits_q == 2'd3 && spd_q < 3'd4) spd_q <= spd_q + 3'd1;
            end else if (miss_l || miss_r) begin
                spd_q  <= 3'd1;
                hits_q <= '0;
            end
        end
    end
`else
    assign spd = 3'd1;
`endif

    assign bus.ball_x      = ball_x_q;
    assign bus.ball_y      = ball_y_q;
    assign bus.score_p1    = sc1_q;
    assign bus.score_p2    = sc2_q;
    assign bus.point_pulse = pulse_q;
    assign bus.game_over   = over_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine: directed rallies with hand-computed
// pins, then randomized frames compared every cycle against an integer game model.
module tb_pong_ball_engine;
    localparam int W = 640, H = 480, B = 4, PW = 5, PH = 50;
    localparam int P1X = 0, P2X = 635, SF = 60, WIN = 9;
`ifdef PONG_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_on = 1'b0;
    int   n_chk = 0, n_err = 0;

    pong_ball_engine_if ifc();
    pong_ball_engine dut (.pixel_clk(clk), .reset(rst), .bus(ifc));

    always #5 clk = ~clk;

    // Game model in plain integers.
    int m_st, m_cnt, m_bx, m_by, m_vx, m_vy, m_s1, m_s2, m_spd, m_hits;
    bit m_pp;

    function automatic void model_reset();
        m_st = 0; m_cnt = 0; m_bx = (W - B) / 2; m_by = (H - B) / 2;
        m_vx = 1; m_vy = 1; m_s1 = 0; m_s2 = 0; m_spd = 1; m_hits = 0; m_pp = 0;
    endfunction

    function automatic bit overlap(input int by, input int py);
        return (by < py + PH) && (py < by + B);
    endfunction

    function automatic void point(input bit left_missed);
        if (left_missed) m_s2 = (m_s2 < WIN) ? m_s2 + 1 : m_s2;
        else             m_s1 = (m_s1 < WIN) ? m_s1 + 1 : m_s1;
        m_pp = 1; m_bx = (W - B) / 2; m_by = (H - B) / 2;
        m_vx = left_missed ? -1 : 1; m_vy = 1; m_spd = 1; m_hits = 0; m_cnt = 0;
        m_st = (m_s1 == WIN || m_s2 == WIN) ? 3 : 1;
    endfunction

    function automatic void model_step();
        int nx, ny;
        bit h1, h2;
        case (m_st)
            0: if (ifc.serve) begin m_st = 1; m_cnt = 0; end
            1: begin
                m_vy = 1;
                if (m_cnt == SF - 1) m_st = 2; else m_cnt++;
            end
            2: begin
                nx = m_bx + m_vx;
                ny = m_by + m_vy;
                h1 = (m_vx < 0) && (nx <= P1X + PW) && overlap(m_by, int'(ifc.p1_y));
                h2 = (m_vx > 0) && (nx + B >= P2X) && overlap(m_by, int'(ifc.p2_y));
                if (ny <= 0)          begin m_by = 0;     m_vy = 1;  end
                else if (ny >= H - B) begin m_by = H - B; m_vy = -1; end
                else                  m_by = ny;
                if (h1 || h2) begin
                    m_hits++;
                    if (SPEEDUP && m_hits % 4 == 0 && m_spd < 4) m_spd++;
                    m_bx = h1 ? P1X + PW : P2X - B;
                    m_vx = h1 ? m_spd : -m_spd;
                end else if (nx < 0 || nx + B > W) begin
                    point(nx < 0);
                end else begin
                    m_bx = nx;
                end
            end
            default: if (ifc.serve) begin m_s1 = 0; m_s2 = 0; m_st = 1; m_cnt = 0; end
        endcase
    endfunction

    task automatic cyc(input bit t, input bit s);
        ifc.frame_tick = t;
        ifc.serve      = s;
        @(posedge clk);
        m_pp = 0;
        if (rst)    model_reset();
        else if (t) model_step();
        #1;
    endtask

    task automatic lit(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            n_chk++;
            if (ifc.state !== 2'(m_st) || ifc.ball_x !== 10'(m_bx) || ifc.ball_y !== 10'(m_by) ||
                ifc.score_p1 !== 4'(m_s1) || ifc.score_p2 !== 4'(m_s2) ||
                ifc.point_pulse !== m_pp || ifc.game_over !== (m_st == 3)) begin
                n_err++;
                $display("FAIL model t=%0t got st=%0d x=%0d y=%0d s=%0d/%0d pp=%0b go=%0b want st=%0d x=%0d y=%0d s=%0d/%0d pp=%0b go=%0b",
                         $time, ifc.state, ifc.ball_x, ifc.ball_y, ifc.score_p1, ifc.score_p2,
                         ifc.point_pulse, ifc.game_over, m_st, m_bx, m_by, m_s1, m_s2, m_pp, m_st == 3);
            end
        end
    end

    task automatic track(input int off1, input int off2);
        int v1, v2;
        v1 = m_by - off1; if (v1 < 0) v1 = 0;
        v2 = m_by - off2; if (v2 < 0) v2 = 0;
        ifc.p1_y = 9'(v1);
        ifc.p2_y = 9'(v2);
    endtask

    initial begin
        ifc.frame_tick = 1'b0; ifc.serve = 1'b0; ifc.p1_y = '0; ifc.p2_y = '0;
        model_reset();
        cyc(0, 0);
        chk_on = 1'b1;
        cyc(0, 0);
        rst = 1'b0;

        // Idle without ticks: serve level alone must not move anything.
        repeat (1000) cyc(0, 1);
        lit("rst_state", int'(ifc.state), 0);
        lit("rst_x", int'(ifc.ball_x), 318);
        lit("rst_y", int'(ifc.ball_y), 238);
        lit("rst_score", int'({ifc.score_p1, ifc.score_p2}), 0);

        // Rally 1: serve held high throughout, right paddle at 380, left at 400.
        ifc.p1_y = 9'd400; ifc.p2_y = 9'd380;
        cyc(1, 1);           lit("serve_state", int'(ifc.state), 1);
        repeat (59) cyc(1, 1); lit("serve_hold", int'(ifc.state), 1);
        cyc(1, 1);           lit("play_state", int'(ifc.state), 2);
        lit("play_x0", int'(ifc.ball_x), 318);
        cyc(1, 1);           lit("t1_x", int'(ifc.ball_x), 319); lit("t1_y", int'(ifc.ball_y), 239);
        repeat (237) cyc(1, 1); lit("t238_y", int'(ifc.ball_y), 476); lit("t238_x", int'(ifc.ball_x), 556);
        cyc(1, 1);           lit("t239_y", int'(ifc.ball_y), 475);
        repeat (74) cyc(1, 1); lit("rhit_x", int'(ifc.ball_x), 631); lit("rhit_y", int'(ifc.ball_y), 401);
        cyc(1, 1);           lit("rhit_next_x", int'(ifc.ball_x), 630);
        repeat (400) cyc(1, 1); lit("top_y", int'(ifc.ball_y), 0); lit("top_x", int'(ifc.ball_x), 230);
        repeat (230) cyc(1, 1); lit("edge_x", int'(ifc.ball_x), 0); lit("edge_y", int'(ifc.ball_y), 230);
        cyc(1, 1);
        lit("miss_p2", int'(ifc.score_p2), 1);
        lit("miss_pulse", int'(ifc.point_pulse), 1);
        lit("miss_state", int'(ifc.state), 1);
        lit("miss_x", int'(ifc.ball_x), 318);
        cyc(0, 0);           lit("pulse_one", int'(ifc.point_pulse), 0);

        // Rally 2: serve leftward, left paddle return, then a right miss.
        ifc.p1_y = 9'd380; ifc.p2_y = 9'd0;
        repeat (60) cyc(1, 0); lit("r2_play", int'(ifc.state), 2);
        repeat (313) cyc(1, 0); lit("lhit_x", int'(ifc.ball_x), 5); lit("lhit_y", int'(ifc.ball_y), 401);
        cyc(1, 0);           lit("lhit_next_x", int'(ifc.ball_x), 6);
        repeat (631) cyc(1, 0); lit("r2_p1", int'(ifc.score_p1), 1);

        // Eight more identical right misses take player 1 to the winning score.
        repeat (8 * (SF + 319)) cyc(1, 0);
        lit("go_state", int'(ifc.state), 3);
        lit("go_flag", int'(ifc.game_over), 1);
        lit("go_p1", int'(ifc.score_p1), 9);
        repeat (5) cyc(1, 0); lit("go_frozen", int'(ifc.score_p1), 9);
        cyc(1, 1);
        lit("restart_state", int'(ifc.state), 1);
        lit("restart_score", int'({ifc.score_p1, ifc.score_p2}), 0);

        // Reset mid-play wins over a coincident tick.
        repeat (70) cyc(1, 0);
        rst = 1'b1; cyc(1, 0); rst = 1'b0;
        lit("midrst_state", int'(ifc.state), 0);
        lit("midrst_x", int'(ifc.ball_x), 318);

        // Randomized frames: paddles either chase the ball or wander.
        for (int i = 0; i < 20000; i++) begin
            rst = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 3) != 0) track($urandom_range(0, 52), $urandom_range(0, 52));
            else begin
                ifc.p1_y = 9'($urandom_range(0, 511));
                ifc.p2_y = 9'($urandom_range(0, 511));
            end
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0);
        end
        rst = 1'b0;
        cyc(0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
